mx3_rr_arbiter: RTL and testbench
=================================

// Module: mx3_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 3:1 mux datapath (mx3 cell column) between 3 requesters.
//  Picks a requester, drives the mux selects cmd0/cmd1 from flops, holds the grant for a packet.
//  Inserts a select-settle gap on every source change. Sits between requester FSMs and a shared sink.
// PARAMETERS
//  MAX_BEATS   16  max beats per grant before forced re-arbitration (1..255)
//  SETTLE_CYC  1   idle cycles after a select change before grant asserts (0..3)
// PORTS
//  ck          in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  req         in   3  per-requester beat valid (req[k] = source ik has a beat)
//  last        in   3  per-requester end-of-packet flag, qualified by req[k]
//  dst_ready   in   1  shared sink accepts the beat on the mux output this cycle
//  gnt         out  3  one-hot grant; beat k transfers when gnt[k] & req[k] & dst_ready
//  cmd0        out  1  mux select bit 0 (registered)
//  cmd1        out  1  mux select bit 1 (registered)
//  dst_valid   out  1  = |(gnt & req); valid toward sink
//  busy        out  1  high in SETTLE or GRANT
// BEHAVIOUR
//  Select code {cmd1,cmd0}: i0 -> 00, i2 -> 01, i1 -> 11; code 10 never driven.
//  Reset (async): state=IDLE, gnt=000, cmd1/cmd0=00, dst_valid=0, busy=0, rr pointer=0, beat_cnt=0.
//  FSM states: IDLE, SETTLE, GRANT.
//  IDLE: if |req, winner = first requester with req set scanning ptr+1, ptr+2, ptr (mod 3).
//   If winner's code == current cmd code, or SETTLE_CYC==0 -> GRANT next cycle; else load code, -> SETTLE.
//   cmd0/cmd1 update on the same edge the winner is latched; gnt stays 000 that edge.
//  SETTLE: count SETTLE_CYC cycles with gnt=000, cmd stable -> GRANT.
//  GRANT: gnt one-hot for winner; beat_cnt increments on each transfer (8-bit, saturates irrelevant).
//   Exit when transfer with last[w]=1, or transfer making beat_cnt==MAX_BEATS -> IDLE next cycle,
//   ptr<=w, beat_cnt<=0. gnt drops on the edge following the final transfer (no extra beat).
//   req[w] dropping without last: grant held (no timeout on idle); dst_valid=0 meanwhile.
//  Latency: request in IDLE, same select -> gnt after 2 edges; different select -> 2+SETTLE_CYC edges.
//  Back-to-back: IDLE always spends exactly 1 cycle; no two grants on consecutive cycles to different k.
//  cmd0/cmd1 never change while gnt!=000 (glitch-free datapath guarantee).
//  Simultaneous req all 3 from reset: order 1,2,0,1,... (ptr=0 start).
//  dst_ready low: no transfer, counters/state hold.
//  Reset mid-packet: all outputs to reset values immediately; packet is dropped, requester re-requests.
// CONFIGURATION
//  MX3_ARB_LOCKOUT_EN: defined -> extra input lock (1b, in) placed after dst_ready; while lock=1
//   IDLE does not start arbitration (GRANT in progress finishes normally); cmd holds.
//  Not defined -> port absent, arbitration never inhibited.
// TESTING
//  Reset: rst_n=0 mid-GRANT -> gnt=000, cmd=00, busy=0 asynchronously, before next ck edge.
//  req=001 single beat last=001, ready=1, SETTLE_CYC=1 -> gnt=001 at edge 2, code 00, one transfer, IDLE.
//  req=111 steady, last=111 every beat -> grant order 1,2,0,1; codes 11,01,00,11; 1 settle gap each switch.
//  req=010, last never, MAX_BEATS=16 -> exactly 16 transfers, gnt drops, regrant to 1 without settle.
//  req=100, ready toggling 1010.. with last on 4th beat -> 4 transfers in 8 GRANT cycles, cmd stable 01.
//  MX3_ARB_LOCKOUT_EN, lock=1 with req=011 -> gnt stays 000; lock=0 -> gnt=010 (ptr 0 rule).

Source files
------------

// File: rtl/mx3_rr_arbiter.sv
// Round-robin sequencer sharing one 3:1 mx3 mux column between three requesters.
// Registered selects, settle gap on source change; optional lock input under MX3_ARB_LOCKOUT_EN.
`timescale 1ns/1ps
module mx3_rr_arbiter #(
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic       dst_ready,
`ifdef MX3_ARB_LOCKOUT_EN
  input  logic       lock,
`endif
  output logic [2:0] gnt,
  output logic       cmd0,
  output logic       cmd1,
  output logic       dst_valid,
  output logic       busy
);

  localparam logic [7:0] MAX_B     = 8'(MAX_BEATS);
  localparam logic [1:0] SETTLE_LD = 2'(SETTLE_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  // Mux select code per requester; 2'b10 is never produced.
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_code = 2'b00;
      2'd1:    sel_code = 2'b11;
      2'd2:    sel_code = 2'b01;
      default: sel_code = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    idx_onehot = 3'b001;
      2'd1:    idx_onehot = 3'b010;
      2'd2:    idx_onehot = 3'b100;
      default: idx_onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      2'd2:    rr_next = 2'd0;
      default: rr_next = 2'd0;
    endcase
  endfunction

  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    bit_at = vec[0];
      2'd1:    bit_at = vec[1];
      2'd2:    bit_at = vec[2];
      default: bit_at = 1'b0;
    endcase
  endfunction

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] win_q;
  logic [1:0] cmd_q;
  logic [2:0] gnt_q;
  logic       busy_q;
  logic [7:0] beat_q;
  logic [1:0] settle_q;

  logic [1:0] cand_a_s;
  logic [1:0] cand_b_s;
  logic [1:0] win_s;
  logic       win_vld_s;
  logic [1:0] win_code_s;
  logic       skip_settle_s;
  logic       arb_en_s;
  logic       xfer_s;
  logic       last_s;
  logic [7:0] beat_nxt_s;
  logic       pkt_end_s;

`ifdef MX3_ARB_LOCKOUT_EN
  assign arb_en_s = ~lock;
`else
  assign arb_en_s = 1'b1;
`endif

  // Round-robin winner search starting just after the last served requester.
  always_comb begin
    cand_a_s  = rr_next(ptr_q);
    cand_b_s  = rr_next(cand_a_s);
    win_s     = ptr_q;
    win_vld_s = 1'b0;
    if (bit_at(req, cand_a_s)) begin
      win_s     = cand_a_s;
      win_vld_s = 1'b1;
    end else if (bit_at(req, cand_b_s)) begin
      win_s     = cand_b_s;
      win_vld_s = 1'b1;
    end else if (bit_at(req, ptr_q)) begin
      win_s     = ptr_q;
      win_vld_s = 1'b1;
    end else begin
      win_s     = ptr_q;
      win_vld_s = 1'b0;
    end
  end

  assign win_code_s    = sel_code(win_s);
  assign skip_settle_s = (win_code_s == cmd_q) || (SETTLE_LD == 2'd0);
  assign xfer_s        = dst_ready & (|(gnt_q & req));
  assign last_s        = |(gnt_q & req & last);
  assign beat_nxt_s    = beat_q + 8'd1;
  assign pkt_end_s     = xfer_s & (last_s | (beat_nxt_s == MAX_B));

  // Arbitration FSM; gnt/cmd/busy are registered here.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      win_q    <= 2'd0;
      cmd_q    <= 2'b00;
      gnt_q    <= 3'b000;
      busy_q   <= 1'b0;
      beat_q   <= 8'd0;
      settle_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_en_s && win_vld_s) begin
            win_q    <= win_s;
            cmd_q    <= win_code_s;
            busy_q   <= 1'b1;
            settle_q <= skip_settle_s ? 2'd0 : SETTLE_LD;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 2'd0) begin
            gnt_q   <= idx_onehot(win_q);
            state_q <= ST_GRANT;
          end else begin
            settle_q <= settle_q - 2'd1;
          end
        end
        ST_GRANT: begin
          // Grant is held while the owner is idle; only a completed packet releases it.
          if (pkt_end_s) begin
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            ptr_q   <= win_q;
            beat_q  <= 8'd0;
            state_q <= ST_IDLE;
          end else if (xfer_s) begin
            beat_q <= beat_nxt_s;
          end
        end
        default: begin
          gnt_q   <= 3'b000;
          busy_q  <= 1'b0;
          beat_q  <= 8'd0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign cmd0      = cmd_q[0];
  assign cmd1      = cmd_q[1];
  assign busy      = busy_q;
  assign dst_valid = |(gnt_q & req);

endmodule

// File: tb/tb_mx3_rr_arbiter.sv
// Scoreboard bench for mx3_rr_arbiter: stimulus pushes expected transfers, a monitor pops them.
// Exercises the lock input when MX3_ARB_LOCKOUT_EN is defined.
`timescale 1ns/1ps
module tb_mx3_rr_arbiter;

  logic       ck = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] last;
  logic       dst_ready;
`ifdef MX3_ARB_LOCKOUT_EN
  logic       lock;
`endif
  logic [2:0] gnt;
  logic       cmd0;
  logic       cmd1;
  logic       dst_valid;
  logic       busy;

  int         issued[3];
  int         consumed[3];
  int         cyc;
  logic [2:0] last_each;
  logic [2:0] no_last;
  logic       ready_toggle;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic [2:0] g;
    logic [1:0] c;
    int         cy;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0] prev_gnt;
  logic [1:0] prev_cmd;

  always #5 ck = ~ck;

  mx3_rr_arbiter #(.MAX_BEATS(16), .SETTLE_CYC(1)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .dst_ready (dst_ready),
`ifdef MX3_ARB_LOCKOUT_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .dst_valid (dst_valid),
    .busy      (busy)
  );

  // Requester model: a requester holds req while it has unsent beats.
  always_comb begin
    req  = 3'b000;
    last = 3'b000;
    for (int k = 0; k < 3; k++) begin
      req[k]  = (issued[k] != consumed[k]);
      last[k] = req[k] & ~no_last[k] & (last_each[k] | ((issued[k] - consumed[k]) == 1));
    end
  end

  assign dst_ready = ready_toggle ? ~cyc[0] : 1'b1;

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      consumed <= '{0, 0, 0};
      cyc      <= 0;
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++)
        if (gnt[k] && req[k] && dst_ready) consumed[k] <= consumed[k] + 1;
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cyc=%0d)", nm, got, want, cyc);
    end
  endtask

  task automatic expect_x(input logic [2:0] g, input logic [1:0] c, input int cy);
    exp_t e;
    e.g  = g;
    e.c  = c;
    e.cy = cy;
    exp_q.push_back(e);
  endtask

  // Monitor: datapath invariants every cycle, scoreboard pop on every transfer.
  always @(negedge ck) begin
    if (rst_n) begin
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      chk("code10_never", int'({cmd1, cmd0} == 2'b10), 0);
      if (prev_gnt != 3'b000 && gnt != 3'b000)
        chk("cmd_stable", int'({cmd1, cmd0}), int'(prev_cmd));
      chk("dst_valid", int'(dst_valid), int'(|(gnt & req)));
      if ((gnt & req) != 3'b000 && dst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", cyc, -1);
        end else begin
          chk("xfer_gnt", int'(gnt), int'(exp_q[0].g));
          chk("xfer_code", int'({cmd1, cmd0}), int'(exp_q[0].c));
          chk("xfer_cyc", cyc, exp_q[0].cy);
          void'(exp_q.pop_front());
        end
      end
      prev_gnt <= gnt;
      prev_cmd <= {cmd1, cmd0};
    end else begin
      prev_gnt <= 3'b000;
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    issued       = '{0, 0, 0};
    last_each    = 3'b000;
    no_last      = 3'b000;
    ready_toggle = 1'b0;
`ifdef MX3_ARB_LOCKOUT_EN
    lock         = 1'b0;
`endif
    exp_q.delete();
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go_to(input int n);
    int g = 0;
    while (cyc != n && g < 200) begin
      @(posedge ck);
      #1;
      g++;
    end
    if (cyc != n) chk("go_to_timeout", cyc, n);
  endtask

  task automatic drain(input string nm);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge ck);
      g++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    issued       = '{0, 0, 0};
    last_each    = 3'b000;
    no_last      = 3'b000;
    ready_toggle = 1'b0;
`ifdef MX3_ARB_LOCKOUT_EN
    lock         = 1'b0;
`endif
    repeat (2) @(posedge ck);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_cmd", int'({cmd1, cmd0}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(dst_valid), 0);

    // A: single beat from i0, same select as reset -> grant after 2 edges.
    do_reset();
    issued[0] = 1;
    expect_x(3'b001, 2'b00, 2);
    go_to(1);
    chk("A_gnt_at1", int'(gnt), 0);
    chk("A_busy_at1", int'(busy), 1);
    go_to(3);
    chk("A_gnt_after", int'(gnt), 0);
    chk("A_busy_after", int'(busy), 0);
    drain("A_drain");

    // B: all three requesting, one-beat packets -> order 1,2,0,1 with settle gaps.
    do_reset();
    last_each = 3'b111;
    issued[1] = 2;
    issued[2] = 1;
    issued[0] = 1;
    expect_x(3'b010, 2'b11, 3);
    expect_x(3'b100, 2'b01, 7);
    expect_x(3'b001, 2'b00, 11);
    expect_x(3'b010, 2'b11, 15);
    go_to(1);
    chk("B_cmd_at_latch", int'({cmd1, cmd0}), 3);
    chk("B_gnt_at_latch", int'(gnt), 0);
    drain("B_drain");
    go_to(16);
    chk("B_gnt_end", int'(gnt), 0);

    // C: endless packet from i1 -> cut at 16 beats, regrant without settle.
    do_reset();
    no_last[1] = 1'b1;
    issued[1]  = 18;
    for (int i = 0; i < 16; i++) expect_x(3'b010, 2'b11, 3 + i);
    expect_x(3'b010, 2'b11, 21);
    expect_x(3'b010, 2'b11, 22);
    go_to(19);
    chk("C_gnt_drop", int'(gnt), 0);
    go_to(20);
    chk("C_busy_rearb", int'(busy), 1);
    drain("C_drain");
    go_to(25);
    chk("C_gnt_held", int'(gnt), 2);
    chk("C_valid_idle", int'(dst_valid), 0);
    chk("C_busy_held", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("C_async_gnt", int'(gnt), 0);
    chk("C_async_cmd", int'({cmd1, cmd0}), 0);
    chk("C_async_busy", int'(busy), 0);

    // D: i2, ready toggling, 4-beat packet -> 4 transfers over 8 grant cycles.
    do_reset();
    ready_toggle = 1'b1;
    issued[2]    = 4;
    expect_x(3'b100, 2'b01, 4);
    expect_x(3'b100, 2'b01, 6);
    expect_x(3'b100, 2'b01, 8);
    expect_x(3'b100, 2'b01, 10);
    go_to(5);
    chk("D_cmd", int'({cmd1, cmd0}), 1);
    chk("D_gnt_stall", int'(gnt), 4);
    drain("D_drain");
    go_to(11);
    chk("D_gnt_end", int'(gnt), 0);

`ifdef MX3_ARB_LOCKOUT_EN
    // E: lock holds off arbitration; release picks i1 first from ptr 0.
    do_reset();
    lock      = 1'b1;
    last_each = 3'b011;
    issued[0] = 1;
    issued[1] = 1;
    expect_x(3'b010, 2'b11, 8);
    expect_x(3'b001, 2'b00, 12);
    go_to(5);
    chk("E_lock_gnt", int'(gnt), 0);
    chk("E_lock_busy", int'(busy), 0);
    chk("E_lock_cmd", int'({cmd1, cmd0}), 0);
    lock = 1'b0;
    drain("E_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
